// File: rtl/gauss_axi_writer.sv
// Streams a filtered frame from a byte-wide buffer into DDR3 as 32-bit AXI writes,
// packing four pixels per word little-endian and keeping a single write in flight.
module gauss_axi_writer #(
  parameter int          IMG_PIXELS = 784,
  parameter int          DATA_WIDTH = 8,
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [31:0]           axi_awaddr,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [31:0]           axi_wdata,
  output logic [3:0]            axi_wstrb,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  input  logic [1:0]            axi_bresp,
  input  logic                  axi_bvalid,
  output logic                  axi_bready
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, RESP, DONE} state_e;

  state_e                state_q;
  logic                  busy_q, done_q, error_q, rd_en_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q, k_q;
  logic [31:0]           awaddr_q, wdata_q;
  logic [3:0]            wstrb_q;
  logic                  awvalid_q, wvalid_q, bready_q;
  logic                  cap_q, aw_done_q, w_done_q;
  logic [1:0]            cap_lane_q;

  logic [31:0]           word_off;
  logic [ADDR_WIDTH-1:0] next_base;
  logic                  last_word, rd_last, aw_ok, w_ok;

  always_comb begin
    word_off  = 32'(k_q) << 2;
    next_base = ADDR_WIDTH'(word_off + 32'd4);
    last_word = (word_off + 32'd4) >= 32'(IMG_PIXELS);
    rd_last   = (rd_addr_q[1:0] == 2'b11) || (rd_addr_q == ADDR_WIDTH'(IMG_PIXELS - 1));
    aw_ok     = aw_done_q | (awvalid_q & axi_awready);
    w_ok      = w_done_q  | (wvalid_q  & axi_wready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      k_q        <= '0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      cap_q      <= 1'b0;
      cap_lane_q <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      // Buffer data lags rd_en by one cycle; remember which lane it belongs to.
      cap_q      <= rd_en_q;
      cap_lane_q <= rd_addr_q[1:0];
      if (cap_q) begin
        for (int i = 0; i < 4; i++) begin
          if (cap_lane_q == 2'(i)) begin
            wdata_q[i*DATA_WIDTH +: DATA_WIDTH] <= rd_data;
            wstrb_q[i]                          <= 1'b1;
          end
        end
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= READ;
            busy_q    <= 1'b1;
            error_q   <= 1'b0;
            k_q       <= '0;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
          end
        end
        READ: begin
          if (rd_en_q) begin
            if (rd_last) rd_en_q   <= 1'b0;
            else         rd_addr_q <= rd_addr_q + 1'b1;
          end else if (cap_q) begin
            // Final capture lands this edge, so the word is complete in WRITE.
            state_q   <= WRITE;
            awaddr_q  <= BASE_ADDR + word_off;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end
        end
        WRITE: begin
          if (awvalid_q && axi_awready) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (wvalid_q && axi_wready) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (aw_ok && w_ok) begin
            state_q  <= RESP;
            bready_q <= 1'b1;
          end
        end
        RESP: begin
          if (axi_bvalid) begin
            bready_q <= 1'b0;
            if (axi_bresp != 2'b00) error_q <= 1'b1;
            if (last_word) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= READ;
              k_q       <= k_q + 1'b1;
              rd_en_q   <= 1'b1;
              rd_addr_q <= next_base;
              wdata_q   <= '0;
              wstrb_q   <= '0;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign axi_awaddr  = awaddr_q;
  assign axi_awvalid = awvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_bready  = bready_q;

endmodule

// File: tb/tb_gauss_axi_writer.sv
// Bench for gauss_axi_writer: scenario table over a full frame with a word-level
// reference model, plus reset-abort and short-frame sequences.
module tb_gauss_axi_writer;

  localparam int          P    = 784;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start;
  logic        busy, done, error, rd_en;
  logic [9:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [31:0] axi_awaddr, axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid, axi_bready;

  logic        s_start, s_busy, s_done, s_error, s_rd_en;
  logic [9:0]  s_rd_addr;
  logic [7:0]  s_rd_data;
  logic [31:0] s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_wvalid, s_bready;

  gauss_axi_writer #(.IMG_PIXELS(P), .DATA_WIDTH(8), .ADDR_WIDTH(10), .BASE_ADDR(BASE)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .error(error),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready));

  gauss_axi_writer #(.IMG_PIXELS(10), .DATA_WIDTH(8), .ADDR_WIDTH(10), .BASE_ADDR(BASE)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .busy(s_busy), .done(s_done), .error(s_error),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
    .axi_awaddr(s_awaddr), .axi_awvalid(s_awvalid), .axi_awready(1'b1),
    .axi_wdata(s_wdata), .axi_wstrb(s_wstrb), .axi_wvalid(s_wvalid), .axi_wready(1'b1),
    .axi_bresp(2'b00), .axi_bvalid(1'b1), .axi_bready(s_bready));

  // Buffer models: synchronous read, data one cycle after rd_en.
  logic [7:0] mem [1024];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];
  always @(posedge clk) if (s_rd_en) s_rd_data <= 8'(s_rd_addr);

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string name;
    bit    buf_rand;
    int    aw_mode;   // 0 always ready, 1 ready after 3 cycles, 2 random
    int    w_mode;
    int    b_mode;    // 0 bvalid always, 1 random
    int    berr_word; // index of the response returning SLVERR, -1 none
    bit    mid_start;
    bit    exp_err;
  } scen_t;
  scen_t tbl [5];

  int aw_mode = 0, w_mode = 0, b_mode = 0, berr_word = -1;
  int aw_wait = 0, w_wait = 0;

  function automatic logic rdy(input int mode, input int waited);
    case (mode)
      0:       return 1'b1;
      1:       return waited >= 3;
      default: return $urandom_range(0, 2) != 0;
    endcase
  endfunction

  // Slave driver: inputs change at negedge+1.
  int b_cnt = 0;
  initial begin
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;
    forever begin
      @(negedge clk); #1;
      if (axi_awvalid) begin
        axi_awready = rdy(aw_mode, aw_wait);
        aw_wait = axi_awready ? 0 : aw_wait + 1;
      end else begin
        axi_awready = (aw_mode == 0);
        aw_wait = 0;
      end
      if (axi_wvalid) begin
        axi_wready = rdy(w_mode, w_wait);
        w_wait = axi_wready ? 0 : w_wait + 1;
      end else begin
        axi_wready = (w_mode == 0);
        w_wait = 0;
      end
      axi_bvalid = (b_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      axi_bresp  = (b_cnt == berr_word) ? 2'b10 : 2'b00;
    end
  end

  // Monitor: samples at negedge+3, when both DUT outputs and slave inputs are settled.
  logic [31:0] aw_q [$], s_aw_q [$];
  logic [35:0] w_q [$], s_w_q [$];
  int  aw_cnt = 0, w_cnt = 0, done_cnt = 0, read_cyc = 0, s_b_cnt = 0, s_done_cnt = 0;
  bit  aw_pend, w_pend, aw_hs_prev, w_hs_prev, err_chk, exp_err_m;
  logic [31:0] aw_pend_addr;
  logic [35:0] w_pend_dat;

  initial begin
    aw_pend = 0; w_pend = 0; aw_hs_prev = 0; w_hs_prev = 0; err_chk = 0; exp_err_m = 0;
    forever begin
      @(negedge clk); #3;
      if (!rst_n) begin
        aw_pend = 0; w_pend = 0; aw_hs_prev = 0; w_hs_prev = 0; err_chk = 0; read_cyc = 0;
      end else begin
        if (err_chk) chk("error_after_b", error, exp_err_m);
        err_chk = 0;
        if (aw_pend) chk("aw_hold", {axi_awvalid, axi_awaddr}, {1'b1, aw_pend_addr});
        if (w_pend) chk("w_hold", {axi_wvalid, axi_wdata, axi_wstrb}, {1'b1, w_pend_dat});
        if (aw_hs_prev) chk("aw_drop", axi_awvalid, 1'b0);
        if (w_hs_prev) chk("w_drop", axi_wvalid, 1'b0);
        if (busy && !done && !axi_awvalid && !axi_wvalid && !axi_bready) read_cyc++;
        else begin
          if (axi_awvalid && read_cyc > 0) chk("read_cycles", read_cyc, 5);
          read_cyc = 0;
        end
        aw_pend = axi_awvalid && !axi_awready;  aw_pend_addr = axi_awaddr;
        w_pend  = axi_wvalid && !axi_wready;    w_pend_dat   = {axi_wdata, axi_wstrb};
        aw_hs_prev = axi_awvalid && axi_awready;
        w_hs_prev  = axi_wvalid && axi_wready;
        if (axi_awvalid && axi_awready) begin
          chk("aw_one_outstanding", aw_cnt - b_cnt, 0);
          aw_q.push_back(axi_awaddr); aw_cnt++;
        end
        if (axi_wvalid && axi_wready) begin
          chk("w_one_outstanding", w_cnt - b_cnt, 0);
          w_q.push_back({axi_wdata, axi_wstrb}); w_cnt++;
        end
        if (axi_bvalid && axi_bready) begin
          if (axi_bresp != 2'b00) exp_err_m = 1;
          b_cnt++; err_chk = 1;
        end
        if (done) done_cnt++;
        if (s_awvalid) s_aw_q.push_back(s_awaddr);
        if (s_wvalid) s_w_q.push_back({s_wdata, s_wstrb});
        if (s_bready) s_b_cnt++;
        if (s_done) begin
          chk("small_done_after_3b", s_b_cnt, 3);
          s_done_cnt++;
        end
      end
    end
  end

  task automatic clear_run();
    aw_q.delete(); w_q.delete();
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; done_cnt = 0; exp_err_m = 0;
  endtask

  task automatic run_frame(input int idx, input bit prev_err);
    scen_t s;
    logic [31:0] ea, ed;
    logic [3:0]  es;
    s = tbl[idx];
    for (int n = 0; n < 1024; n++) mem[n] = s.buf_rand ? 8'($urandom) : 8'(n);
    aw_mode = s.aw_mode; w_mode = s.w_mode; b_mode = s.b_mode; berr_word = s.berr_word;
    clear_run();
    @(negedge clk);
    if (prev_err) chk({s.name, "_err_held"}, error, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({s.name, "_busy_after_start"}, busy, 1'b1);
    chk({s.name, "_err_cleared"}, error, 1'b0);
    for (int c = 0; c < 40000; c++) begin
      if (done_cnt != 0) break;
      start = s.mid_start && (c == 100);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk({s.name, "_done_once"}, done_cnt, 1);
    chk({s.name, "_idle_busy"}, busy, 1'b0);
    chk({s.name, "_error"}, error, s.exp_err);
    chk({s.name, "_aw_count"}, aw_q.size(), (P + 3) / 4);
    chk({s.name, "_w_count"}, w_q.size(), (P + 3) / 4);
    for (int j = 0; j < (P + 3) / 4; j++) begin
      ea = BASE + 32'(4 * j);
      ed = '0; es = '0;
      for (int i = 0; i < 4; i++) begin
        if (4 * j + i < P) begin
          ed = ed | (32'(mem[4 * j + i]) << (8 * i));
          es[i] = 1'b1;
        end
      end
      if (j < aw_q.size()) chk($sformatf("%s_addr%0d", s.name, j), aw_q[j], ea);
      if (j < w_q.size()) chk($sformatf("%s_word%0d", s.name, j), w_q[j], {ed, es});
    end
  endtask

  logic [31:0] s_exp_a [3];
  logic [35:0] s_exp_w [3];

  initial begin
    tbl[0] = '{"seq_ready1",  1'b0, 0, 0, 0, -1, 1'b0, 1'b0};
    tbl[1] = '{"aw_delay3",   1'b0, 1, 0, 0, -1, 1'b1, 1'b0};
    tbl[2] = '{"w_delay3",    1'b1, 0, 1, 0, -1, 1'b0, 1'b0};
    tbl[3] = '{"bresp_err5",  1'b1, 2, 2, 0,  5, 1'b0, 1'b1};
    tbl[4] = '{"random_all",  1'b1, 2, 2, 1, -1, 1'b1, 1'b0};
    s_exp_a = '{32'h0, 32'h4, 32'h8};
    s_exp_w = '{{32'h03020100, 4'hF}, {32'h07060504, 4'hF}, {32'h00000908, 4'h3}};

    rst_n = 1'b0; start = 1'b0; s_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {busy, done, error, rd_en, axi_awvalid, axi_wvalid, axi_bready}, 7'b0);
    chk("rst_rd_addr", rd_addr, 10'd0);
    chk("rst_awaddr", axi_awaddr, 32'd0);
    chk("rst_wdata_strb", {axi_wdata, axi_wstrb}, 36'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      if (i > 0) run_frame(i, tbl[i-1].exp_err);
      else       run_frame(i, 1'b0);
    end

    // Reset while word 50 is being presented on the AXI bus.
    aw_mode = 0; w_mode = 0; b_mode = 0; berr_word = -1;
    for (int n = 0; n < 1024; n++) mem[n] = 8'(n);
    clear_run();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      if (axi_awvalid && aw_cnt == 50) break;
      @(negedge clk);
    end
    chk("rst_mid_at_word50", {axi_awvalid, 32'(aw_cnt)}, {1'b1, 32'd50});
    rst_n = 1'b0;
    #1;
    chk("rst_mid_immediate", {axi_awvalid, axi_wvalid, axi_bready, rd_en, busy}, 5'b0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_mid_hold", {axi_awvalid, axi_wvalid, axi_bready}, 3'b0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mid_idle", {busy, axi_awvalid, axi_wvalid}, 3'b0);
    chk("rst_mid_no_more_aw", aw_cnt, 50);
    run_frame(0, 1'b0);

    // Ten-pixel frame: partial last word.
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (s_done_cnt != 0) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("small_done_once", s_done_cnt, 1);
    chk("small_idle", {s_busy, s_error}, 2'b0);
    chk("small_aw_count", s_aw_q.size(), 3);
    chk("small_w_count", s_w_q.size(), 3);
    for (int j = 0; j < 3; j++) begin
      if (j < s_aw_q.size()) chk($sformatf("small_addr%0d", j), s_aw_q[j], s_exp_a[j]);
      if (j < s_w_q.size()) chk($sformatf("small_word%0d", j), s_w_q[j], s_exp_w[j]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
